// File: rtl/excess3_to_bcd_stream.sv
// Excess-3 to BCD stream decoder: one digit per cycle in, MSD first,
// packed right-aligned BCD numbers out over a valid/ready handshake.
module excess3_to_bcd_stream #(
   parameter int  DIGITS = 4,
   localparam int CW     = $clog2(DIGITS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_e3,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_bcd,
   output logic                out_err,
   output logic [CW-1:0]       out_ndig
);

   logic [4*DIGITS-1:0] acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                vld_q, vld_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                oerr_q, oerr_d;
   logic [CW-1:0]       ndig_q, ndig_d;

   logic                illegal;
   logic [3:0]          dec;
   logic                accept;
   logic                done;
   logic [CW-1:0]       cnt_inc;
   logic [4*DIGITS+3:0] wide;
   logic [4*DIGITS-1:0] acc_shift;

   assign in_ready  = ~vld_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign illegal   = (in_e3 < 4'h3) | (in_e3 > 4'hC);
   assign dec       = illegal ? 4'hF : in_e3 - 4'd3;
   assign cnt_inc   = cnt_q + CW'(1);
   // Wide concat keeps the shift legal for DIGITS=1
   assign wide      = {acc_q, dec};
   assign acc_shift = wide[4*DIGITS-1:0];
   assign done      = accept & (in_last | (cnt_inc == CW'(DIGITS)));

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      vld_d  = vld_q;
      bcd_d  = bcd_q;
      oerr_d = oerr_q;
      ndig_d = ndig_q;
      if (vld_q && out_ready) begin
         vld_d = 1'b0;
      end
      if (done) begin
         acc_d  = '0;
         cnt_d  = '0;
         err_d  = 1'b0;
         vld_d  = 1'b1;
         bcd_d  = acc_shift;
         oerr_d = err_q | illegal;
         ndig_d = cnt_inc;
      end else if (accept) begin
         acc_d = acc_shift;
         cnt_d = cnt_inc;
         err_d = err_q | illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         vld_q  <= 1'b0;
         bcd_q  <= '0;
         oerr_q <= 1'b0;
         ndig_q <= '0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         vld_q  <= vld_d;
         bcd_q  <= bcd_d;
         oerr_q <= oerr_d;
         ndig_q <= ndig_d;
      end
   end

   assign out_valid = vld_q;
   assign out_bcd   = bcd_q;
   assign out_err   = oerr_q;
   assign out_ndig  = ndig_q;

endmodule

// File: tb/tb_excess3_to_bcd_stream.sv
// Directed bench for excess3_to_bcd_stream with DIGITS=4.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_excess3_to_bcd_stream;

   localparam int DIGITS = 4;
   localparam int CW     = $clog2(DIGITS + 1);

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [3:0]          in_e3;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [4*DIGITS-1:0] out_bcd;
   logic                out_err;
   logic [CW-1:0]       out_ndig;

   int n_checks = 0;
   int n_fail   = 0;

   excess3_to_bcd_stream #(.DIGITS(DIGITS)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_e3(in_e3),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bcd(out_bcd),
      .out_err(out_err),
      .out_ndig(out_ndig)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one digit; it must be accepted on the coming edge
   task automatic push(input logic [3:0] e3, input logic last);
      in_valid = 1'b1;
      in_e3    = e3;
      in_last  = last;
      #0;
      chk("push_in_ready", 32'(in_ready), 32'd1);
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
   endtask

   task automatic chk_out(input string tag, input logic [15:0] bcd,
                          input logic err, input logic [CW-1:0] nd);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bcd"},   32'(out_bcd),   32'(bcd));
      chk({tag, "_err"},   32'(out_err),   32'(err));
      chk({tag, "_ndig"},  32'(out_ndig),  32'(nd));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_e3     = 4'h0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_bcd",   32'(out_bcd),   32'd0);
      chk("rst_err",   32'(out_err),   32'd0);
      chk("rst_ndig",  32'(out_ndig),  32'd0);
      chk("rst_ready", 32'(in_ready),  32'd1);

      // Full four-digit number
      push(4'h4, 1'b0);
      push(4'h8, 1'b0);
      push(4'hA, 1'b0);
      chk("partial_novalid", 32'(out_valid), 32'd0);
      push(4'hC, 1'b1);
      chk_out("full", 16'h1579, 1'b0, 3'd4);

      // Short number, back to back
      push(4'h6, 1'b0);
      chk("drain_novalid", 32'(out_valid), 32'd0);
      push(4'h3, 1'b1);
      chk_out("short", 16'h0030, 1'b0, 3'd2);

      // Illegal code, then a clean number
      push(4'h5, 1'b0);
      push(4'h1, 1'b0);
      push(4'h7, 1'b0);
      push(4'h3, 1'b1);
      chk_out("illegal", 16'h2F40, 1'b1, 3'd4);
      push(4'h4, 1'b0);
      push(4'h4, 1'b1);
      chk_out("after_err", 16'h0011, 1'b0, 3'd2);

      // Backpressure
      idle();
      chk("idle_novalid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      push(4'h4, 1'b0);
      push(4'h8, 1'b0);
      push(4'hA, 1'b0);
      push(4'hC, 1'b1);
      in_valid = 1'b1;
      in_e3    = 4'h3;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk_out("bp_hold", 16'h1579, 1'b0, 3'd4);
         tick();
      end
      out_ready = 1'b1;
      #0;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      chk_out("bp_next", 16'h0000, 1'b0, 3'd1);

      // Reset mid-number
      push(4'h9, 1'b0);
      push(4'h9, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_bcd",   32'(out_bcd),   32'd0);
      push(4'h3, 1'b0);
      push(4'h4, 1'b0);
      push(4'h5, 1'b0);
      push(4'h6, 1'b0);
      chk_out("postrst", 16'h0123, 1'b0, 3'd4);

      // All legal codes streamed continuously
      for (int c = 3; c <= 12; c++) begin
         push(4'(c), (c == 12));
         if (c == 6) chk_out("exh0", 16'h0123, 1'b0, 3'd4);
         if (c == 7) chk("exh_gap", 32'(out_valid), 32'd0);
         if (c == 10) chk_out("exh1", 16'h4567, 1'b0, 3'd4);
         if (c == 12) chk_out("exh2", 16'h0089, 1'b0, 3'd2);
      end
      idle();
      chk("final_novalid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
